mbssoc_ram_arbiter: RTL
=======================

Name: mbssoc_ram_arbiter

Overview:
- Round-robin arbiter that shares the single SoC RAM port among CORE_NUM cores.
- Each core raises a read or write request. The arbiter grants one core at a time and drives the RAM strobes, address and write data for that core.
- For reads, it captures RAM data after RAM_LAT cycles and returns a one-cycle ack to the granted core.
- It holds every pending, un-acked requester in pause. It sits between the cores' memory-stage buses and the RAM.

Parameters:
- CORE_NUM, 2, number of requesting cores (>=2).
- ADDR_WIDTH, 32, RAM address width.
- DATA_WIDTH, 32, RAM data width.
- RAM_LAT, 1, RAM read latency in cycles from the strobe cycle to valid ram_rdata (>=1; 0 unsupported).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_re  in  CORE_NUM  per-core read request.
- req_we  in  CORE_NUM  per-core write request.
- req_addr  in  CORE_NUM*ADDR_WIDTH  packed addresses; core i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  CORE_NUM*DATA_WIDTH  packed write data, same packing.
- cpu_pause  out  CORE_NUM  stall to core i.
- ack  out  CORE_NUM  one-cycle completion pulse to core i.
- rdata  out  DATA_WIDTH  captured read data; shared by all cores, qualified by ack.
- busy  out  1  high when state != IDLE.
- grant_id  out  $clog2(CORE_NUM)  index of the granted core; holds its last value in IDLE.
- ram_re  out  1  RAM read strobe.
- ram_we  out  1  RAM write strobe.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM read data.

Behaviour:
- Request definitions:
  - req[i] = req_re[i] | req_we[i].
  - If both strobes are high, the request is a write; the read is ignored.
- Requester rules:
  - Hold the strobe, addr and wdata stable from assertion until the ack cycle.
  - Deassert, or present a new request, in the cycle after ack.
- Reset (async): state=IDLE, rr_ptr=0, grant_id=0, ack=0, rdata=0, ram_re=ram_we=0, busy=0, wait counter=0.
- ram_addr/ram_wdata:
  - Registered copies of the granted core's addr/wdata, captured at grant.
  - Reset value 0.
  - Change only when a grant is taken.
- cpu_pause:
  - Combinational: cpu_pause[i] = req[i] & ~ack[i].
  - In reset it equals req.
  - A requester is never paused in its own ack cycle.
- FSM states:
  - IDLE:
    - If any req, the winner is the first i with req[i] searching rr_ptr, rr_ptr+1, … mod CORE_NUM.
    - Register grant_id=winner, latch addr/wdata and op type.
    - Set rr_ptr=(winner+1) mod CORE_NUM; go to ACCESS.
    - No req: stay.
  - ACCESS: exactly one cycle.
    - ram_re=1 for a read, ram_we=1 for a write; the other strobe is 0.
    - Read: load counter=RAM_LAT-1 and go to WAIT.
    - Write: go to RESP.
  - WAIT: strobes 0.
    - If counter==0, sample ram_rdata into rdata at this edge and go to RESP.
    - Else decrement.
  - RESP: one cycle.
    - ack[grant_id]=1, all other ack bits 0.
    - rdata holds the sampled value; writes leave rdata unchanged.
    - No arbitration in this state. Go to IDLE.
- Latency, with the request first visible in IDLE cycle t:
  - Write: strobe at t+1, ack at t+2.
  - Read: strobe at t+1, ram_rdata valid at t+1+RAM_LAT, ack and rdata at t+2+RAM_LAT.
- Fairness: after core k is served, core k has lowest priority. Any waiting core is granted within CORE_NUM-1 other transactions.
- Requests arriving or changing while busy: ignored until IDLE; such cores stay paused.
- Illegal withdrawal of the granted request mid-transaction: the transaction completes anyway and ack still pulses.
- Withdrawal of an ungranted request: dropped silently.
- Reset mid-transaction: strobes drop immediately (async), FSM returns to IDLE, no ack is issued, rr_ptr=0.
- ram_re and ram_we are never high together and are never high outside ACCESS.

Test Plan:
- Single write: core0 req_we=1, addr=0x10, wdata=0xDEADBEEF at IDLE cycle t -> ram_we=1, ram_addr=0x10, ram_wdata=0xDEADBEEF in t+1; ack[0]=1 in t+2; cpu_pause[0]=1 in t..t+1, 0 in t+2.
- Read latency with RAM_LAT=2: core1 reads 0x20, RAM returns 0x12345678 two cycles after its strobe -> ram_re in t+1, ack[1]=1 and rdata=0x12345678 in t+4; busy high t+1..t+4.
- Simultaneous requests after reset: both cores write -> core0 served first, then core1 (grant_id 0 then 1); cpu_pause[1] stays high until its ack.
- Round-robin fairness: core0 re-requests immediately after every ack while core1 holds its request -> grants alternate 0,1,0,1; core0 never served twice in a row while core1 waits.
- Read+write same core: req_re=req_we=1 -> only ram_we strobes and rdata is unchanged.
- Reset during WAIT: assert rst_n=0 in WAIT -> ram_re/ram_we/ack/busy read 0 immediately, no ack is issued after release, and the next arbitration starts from core0.

Source files
------------

// File: rtl/mbssoc_ram_arbiter_if.sv
// Core-side request bus and RAM-side port of the shared SoC RAM arbiter.
// slave is the arbiter's view; master is the cores-plus-RAM environment.
interface mbssoc_ram_arbiter_if #(
    parameter int CORE_NUM   = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int GW = $clog2(CORE_NUM);

    logic [CORE_NUM-1:0]            req_re;
    logic [CORE_NUM-1:0]            req_we;
    logic [CORE_NUM*ADDR_WIDTH-1:0] req_addr;
    logic [CORE_NUM*DATA_WIDTH-1:0] req_wdata;
    logic [CORE_NUM-1:0]            cpu_pause;
    logic [CORE_NUM-1:0]            ack;
    logic [DATA_WIDTH-1:0]          rdata;
    logic                           busy;
    logic [GW-1:0]                  grant_id;
    logic                           ram_re;
    logic                           ram_we;
    logic [ADDR_WIDTH-1:0]          ram_addr;
    logic [DATA_WIDTH-1:0]          ram_wdata;
    logic [DATA_WIDTH-1:0]          ram_rdata;

    modport slave (
        input  req_re, req_we, req_addr, req_wdata, ram_rdata,
        output cpu_pause, ack, rdata, busy, grant_id,
               ram_re, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output req_re, req_we, req_addr, req_wdata, ram_rdata,
        input  cpu_pause, ack, rdata, busy, grant_id,
               ram_re, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mbssoc_ram_arbiter.sv
// Round-robin arbiter sharing one SoC RAM port among CORE_NUM cores.
// One transaction at a time: IDLE -> ACCESS -> (WAIT x RAM_LAT) -> RESP.
module mbssoc_ram_arbiter #(
    parameter int CORE_NUM   = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RAM_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mbssoc_ram_arbiter_if.slave  bus
);
    localparam int GW = $clog2(CORE_NUM);
    localparam int CW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(RAM_LAT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t                state, state_nxt;
    logic [CORE_NUM-1:0]   req, ack_v;
    logic [GW-1:0]         rr_ptr, grant_id, winner, idx;
    logic                  win_vld, op_we;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic [ADDR_WIDTH-1:0] addr_a  [CORE_NUM];
    logic [DATA_WIDTH-1:0] wdata_a [CORE_NUM];

    assign req = bus.req_re | bus.req_we;

    for (genvar i = 0; i < CORE_NUM; i++) begin : g_core
        assign addr_a[i]  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_a[i] = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        assign ack_v[i]   = (state == RESP) && (grant_id == GW'(i));
    end

    // First requester at or after rr_ptr, wrapping modulo CORE_NUM.
    always_comb begin
        winner  = '0;
        win_vld = 1'b0;
        idx     = '0;
        for (int k = 0; k < CORE_NUM; k++) begin
            idx = GW'((int'(rr_ptr) + k) % CORE_NUM);
            if (!win_vld && req[idx]) begin
                winner  = idx;
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (win_vld) state_nxt = ACCESS;
            ACCESS:  state_nxt = op_we ? RESP : WAIT;
            WAIT:    if (cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            op_we    <= 1'b0;
            cnt      <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && win_vld) begin
                grant_id <= winner;
                op_we    <= bus.req_we[winner];  // write wins when both strobes are set
                addr_q   <= addr_a[winner];
                wdata_q  <= wdata_a[winner];
                rr_ptr   <= GW'((int'(winner) + 1) % CORE_NUM);
            end
            if (state == ACCESS)
                cnt <= CNT_INIT;
            else if (state == WAIT && cnt != '0)
                cnt <= cnt - 1'b1;
            if (state == WAIT && cnt == '0)
                rdata_q <= bus.ram_rdata;
        end
    end

    assign bus.ram_re    = (state == ACCESS) && !op_we;
    assign bus.ram_we    = (state == ACCESS) && op_we;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = (state != IDLE);
    assign bus.grant_id  = grant_id;
    assign bus.ack       = ack_v;
    assign bus.cpu_pause = req & ~ack_v;
endmodule
